// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction fetch controller sitting on the consumer side of the PC
// register. It reads the current PC every cycle and drives the next PC back.
// The PC register loads PC_Next on every clock. Instruction-memory reads use
// a req/ack handshake. Returned words are queued in a small FIFO and
// presented to decode with a valid/ready handshake. Branch/jump redirects
// flush the FIFO. A redirect that lands behind an outstanding read is parked
// until that read completes.
//
// Parameters
//   BUF_DEPTH      instruction buffer entries (2 or 4)
//
// Ports
//   Clk            clock, rising edge
//   Reset          synchronous, active-high
//   PC_Out         current PC from the PC register
//   PC_Next        next PC to the PC register (combinational)
//   Mem_Req        instruction read request
//   Mem_Addr       read address (always PC_Out)
//   Mem_Ack        read complete, Mem_Data valid this cycle
//   Mem_Data       returned instruction word
//   Redirect       branch/jump taken (single-cycle pulse)
//   Redirect_Addr  branch/jump target
//   Instr          head-of-buffer instruction
//   Instr_PC       address of Instr
//   Instr_Valid    buffer non-empty
//   Instr_Ready    decode accepts the head entry
//   Fetch_Err      misaligned-redirect trap flag (sticky until Reset)
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a non-word-aligned
//                           target traps into ERR. When undefined, the low
//                           two target bits are forced to zero and
//                           Fetch_Err is tied low.
//
// States
//   state | meaning
//   IDLE  | first cycle after Reset, no request issued
//   FETCH | normal fetching into the buffer
//   DRAIN | redirect parked behind an outstanding read; acked data dropped
//   ERR   | misaligned-redirect trap, only Reset leaves
// ----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC_Out,
    output logic [31:0] PC_Next,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Data,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Addr,
    output logic [31:0] Instr,
    output logic [31:0] Instr_PC,
    output logic        Instr_Valid,
    input  logic        Instr_Ready,
    output logic        Fetch_Err
);

    localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pend_q, pend_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               outst_q;
    logic [31:0]        last_instr_q;
    logic [31:0]        last_pc_q;
    logic [31:0]        buf_instr_q [BUF_DEPTH];
    logic [31:0]        buf_pc_q    [BUF_DEPTH];

    logic [31:0]        redir_addr;
    logic               trap;
    logic               redir_ok;
    logic               ack_vld;
    logic               rd_busy;
    logic               push;
    logic               flush;
    logic               do_push;
    logic               do_pop;

    // ------------------------------------------------------------------
    // Redirect target conditioning
    // ------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_addr = Redirect_Addr;
    assign trap       = Redirect && (Redirect_Addr[1:0] != 2'b00) && (state_q != ST_ERR);
    assign Fetch_Err  = (state_q == ST_ERR);
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^Redirect_Addr[1:0];
    assign redir_addr = {Redirect_Addr[31:2], 2'b00};
    assign trap       = 1'b0;
    assign Fetch_Err  = 1'b0;
`endif

    assign redir_ok = Redirect && !trap && (state_q != ST_ERR);

    // ------------------------------------------------------------------
    // Memory request
    // ------------------------------------------------------------------
    // A request already in flight keeps Mem_Req high even if the buffer
    // has since filled, so the address stays stable until the ack.
    assign Mem_Req  = !Reset
                   && ((state_q == ST_FETCH) || (state_q == ST_DRAIN))
                   && ((count_q < DEPTH_C) || outst_q);
    assign Mem_Addr = PC_Out;
    assign ack_vld  = Mem_Req && Mem_Ack;
    assign rd_busy  = Mem_Req && !Mem_Ack;

    // ------------------------------------------------------------------
    // Next state / next PC
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        PC_Next = PC_Out;
        push    = 1'b0;
        flush   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redir_ok) begin
                    PC_Next = redir_addr;
                    flush   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (redir_ok) begin
                    flush = 1'b1;
                    if (rd_busy) begin
                        // Read in flight: hold the address, park the target.
                        state_d = ST_DRAIN;
                        pend_d  = redir_addr;
                    end else begin
                        // No read in flight, or the ack is this cycle and its
                        // data is dropped in favour of the redirect.
                        PC_Next = redir_addr;
                    end
                end else if (ack_vld) begin
                    PC_Next = PC_Out + 32'd4;
                    push    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (redir_ok) begin
                    flush = 1'b1;
                    if (rd_busy) begin
                        pend_d = redir_addr;
                    end else begin
                        PC_Next = redir_addr;
                        state_d = ST_FETCH;
                    end
                end else if (ack_vld) begin
                    PC_Next = pend_q;
                    state_d = ST_FETCH;
                end
            end
            ST_ERR: begin
                flush = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (trap) begin
            state_d = ST_ERR;
            pend_d  = pend_q;
            PC_Next = PC_Out;
            push    = 1'b0;
            flush   = 1'b1;
        end

        if (Reset) begin
            PC_Next = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer control
    // ------------------------------------------------------------------
    assign Instr_Valid = (count_q != '0);
    assign do_push     = push && (count_q != DEPTH_C) && !flush;
    assign do_pop      = Instr_Valid && Instr_Ready && !flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Head entry when non-empty, otherwise the last value shown.
    assign Instr    = Instr_Valid ? buf_instr_q[rd_ptr_q] : last_instr_q;
    assign Instr_PC = Instr_Valid ? buf_pc_q[rd_ptr_q]    : last_pc_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            pend_q       <= 32'd0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            outst_q      <= 1'b0;
            last_instr_q <= 32'd0;
            last_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            outst_q      <= rd_busy && (state_d != ST_ERR);
            last_instr_q <= Instr;
            last_pc_q    <= Instr_PC;
        end
    end

    // Storage is only read while valid, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (!Reset && do_push) begin
            buf_instr_q[wr_ptr_q] <= Mem_Data;
            buf_pc_q[wr_ptr_q]    <= PC_Out;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PC_Out;
    logic [31:0] PC_Next;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_Data;
    logic        Redirect;
    logic [31:0] Redirect_Addr;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Fetch_Err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_pc   [$];
    logic [31:0] sb_data [$];

    instr_fetch_ctrl #(.BUF_DEPTH(2)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .PC_Out        (PC_Out),
        .PC_Next       (PC_Next),
        .Mem_Req       (Mem_Req),
        .Mem_Addr      (Mem_Addr),
        .Mem_Ack       (Mem_Ack),
        .Mem_Data      (Mem_Data),
        .Redirect      (Redirect),
        .Redirect_Addr (Redirect_Addr),
        .Instr         (Instr),
        .Instr_PC      (Instr_PC),
        .Instr_Valid   (Instr_Valid),
        .Instr_Ready   (Instr_Ready),
        .Fetch_Err     (Fetch_Err)
    );

    always #5 Clk = ~Clk;

    // PC register: loads unconditionally every clock.
    always @(posedge Clk) PC_Out <= PC_Next;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    // Instruction memory returns a word derived from the address.
    assign Mem_Data = word_at(Mem_Addr);

    // Scoreboard: compare every accepted head entry against the queue.
    always @(negedge Clk) begin
        if (!Reset && Instr_Valid && Instr_Ready) begin
            n_checks++;
            if (sb_pc.size() == 0) begin
                n_fail++;
                $display("FAIL sb_pop: unexpected entry Instr_PC=%h Instr=%h, nothing expected", Instr_PC, Instr);
            end else begin
                logic [31:0] e_pc, e_d;
                e_pc = sb_pc.pop_front();
                e_d  = sb_data.pop_front();
                if (Instr_PC !== e_pc || Instr !== e_d) begin
                    n_fail++;
                    $display("FAIL sb_pop: got PC=%h instr=%h, expected PC=%h instr=%h", Instr_PC, Instr, e_pc, e_d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic rdy, input logic red, input logic [31:0] ra);
        Mem_Ack       = ack;
        Instr_Ready   = rdy;
        Redirect      = red;
        Redirect_Addr = ra;
    endtask

    task automatic expect_push(input logic [31:0] a);
        sb_pc.push_back(a);
        sb_data.push_back(word_at(a));
    endtask

    task automatic sb_clear();
        sb_pc.delete();
        sb_data.delete();
    endtask

    // Leaves the bench at the start of the IDLE cycle after reset.
    task automatic do_reset();
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        sb_clear();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        tick();
        @(negedge Clk);
        n_checks++;
        if (PC_Next !== 32'd0 || Mem_Req !== 1'b0 || Instr_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: PC_Next=%h Mem_Req=%b Valid=%b, expected 0/0/0", PC_Next, Mem_Req, Instr_Valid);
        end
        n_checks++;
        if (Instr !== 32'd0 || Instr_PC !== 32'd0 || Fetch_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: Instr=%h Instr_PC=%h Fetch_Err=%b, expected 0/0/0", Instr, Instr_PC, Fetch_Err);
        end
        tick();
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_req: Mem_Req=%b expected 0", Mem_Req);
        end
        tick();
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b1 || Mem_Addr !== 32'd0) begin
            n_fail++;
            $display("FAIL first_req: Mem_Req=%b Mem_Addr=%h, expected 1/00000000", Mem_Req, Mem_Addr);
        end
        // Reset in the middle of an outstanding read; a late ack is ignored.
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b0 || PC_Next !== 32'd0) begin
            n_fail++;
            $display("FAIL late_ack: Mem_Req=%b PC_Next=%h, expected 0/00000000", Mem_Req, PC_Next);
        end
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        @(negedge Clk);
        n_checks++;
        if (Instr_Valid !== 1'b0 || Mem_Addr !== 32'd0 || Mem_Req !== 1'b1) begin
            n_fail++;
            $display("FAIL late_ack_after: Valid=%b Mem_Addr=%h Mem_Req=%b, expected 0/00000000/1", Instr_Valid, Mem_Addr, Mem_Req);
        end
    endtask

    task automatic test_stream();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            expect_push(32'(4 * k));
            @(negedge Clk);
            n_checks++;
            if (Mem_Req !== 1'b1 || Mem_Addr !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_addr[%0d]: Mem_Req=%b Mem_Addr=%h, expected 1/%h", k, Mem_Req, Mem_Addr, 32'(4 * k));
            end
            if (k > 0) begin
                n_checks++;
                if (Instr_Valid !== 1'b1 || Instr_PC !== 32'(4 * (k - 1))) begin
                    n_fail++;
                    $display("FAIL stream_pc[%0d]: Valid=%b Instr_PC=%h, expected 1/%h", k, Instr_Valid, Instr_PC, 32'(4 * (k - 1)));
                end
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        @(negedge Clk);
        n_checks++;
        if (sb_pc.size() != 0 || Instr_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: %0d entries left, Valid=%b, expected 0/0", sb_pc.size(), Instr_Valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        expect_push(32'h0);
        tick();
        expect_push(32'h4);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if (Mem_Req !== 1'b0 || PC_Out !== 32'h8 || Instr_Valid !== 1'b1 || Instr_PC !== 32'h0) begin
                n_fail++;
                $display("FAIL bp_full[%0d]: Mem_Req=%b PC_Out=%h Valid=%b Instr_PC=%h, expected 0/8/1/0", i, Mem_Req, PC_Out, Instr_Valid, Instr_PC);
            end
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: Mem_Req=%b expected 0", Mem_Req);
        end
        tick();
        expect_push(32'h8);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h8 || Instr_PC !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_resume: Mem_Req=%b Mem_Addr=%h Instr_PC=%h, expected 1/8/4", Mem_Req, Mem_Addr, Instr_PC);
        end
        tick();
        expect_push(32'hC);
        @(negedge Clk);
        n_checks++;
        if (Mem_Addr !== 32'hC || Instr_PC !== 32'h8) begin
            n_fail++;
            $display("FAIL bp_next: Mem_Addr=%h Instr_PC=%h, expected C/8", Mem_Addr, Instr_PC);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        n_checks++;
        if (sb_pc.size() != 0) begin
            n_fail++;
            $display("FAIL bp_end: %0d entries left, expected 0", sb_pc.size());
        end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_push(32'(4 * k));
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h300);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h10 || PC_Next !== 32'h10) begin
            n_fail++;
            $display("FAIL drain_enter: Mem_Req=%b Mem_Addr=%h PC_Next=%h, expected 1/10/10", Mem_Req, Mem_Addr, PC_Next);
        end
        tick();
        sb_clear();
        drive(1'b0, 1'b1, 1'b1, 32'h100);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h10 || Instr_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_hold: Mem_Req=%b Mem_Addr=%h Valid=%b, expected 1/10/0", Mem_Req, Mem_Addr, Instr_Valid);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h10) begin
            n_fail++;
            $display("FAIL drain_wait: Mem_Req=%b Mem_Addr=%h, expected 1/10", Mem_Req, Mem_Addr);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (PC_Next !== 32'h100) begin
            n_fail++;
            $display("FAIL drain_target: PC_Next=%h expected 00000100", PC_Next);
        end
        tick();
        expect_push(32'h100);
        @(negedge Clk);
        n_checks++;
        if (Mem_Addr !== 32'h100 || Mem_Req !== 1'b1 || Instr_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_resume: Mem_Addr=%h Mem_Req=%b Valid=%b, expected 100/1/0", Mem_Addr, Mem_Req, Instr_Valid);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Instr_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_valid: Valid=%b expected 1", Instr_Valid);
        end
        tick();
        n_checks++;
        if (sb_pc.size() != 0) begin
            n_fail++;
            $display("FAIL drain_end: %0d entries left, expected 0", sb_pc.size());
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        expect_push(32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h200);
        @(negedge Clk);
        n_checks++;
        if (PC_Next !== 32'h200 || Instr_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rack_next: PC_Next=%h Valid=%b, expected 200/1", PC_Next, Instr_Valid);
        end
        tick();
        sb_clear();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        expect_push(32'h200);
        @(negedge Clk);
        n_checks++;
        if (Instr_Valid !== 1'b0 || Mem_Addr !== 32'h200 || Mem_Req !== 1'b1) begin
            n_fail++;
            $display("FAIL rack_after: Valid=%b Mem_Addr=%h Mem_Req=%b, expected 0/200/1", Instr_Valid, Mem_Addr, Mem_Req);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Instr_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rack_valid: Valid=%b expected 1", Instr_Valid);
        end
        tick();
        n_checks++;
        if (sb_pc.size() != 0) begin
            n_fail++;
            $display("FAIL rack_end: %0d entries left, expected 0", sb_pc.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge Clk);
        n_checks++;
        if (Mem_Req !== 1'b0 || PC_Next !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_redir: Mem_Req=%b PC_Next=%h, expected 0/FFFFFFFC", Mem_Req, PC_Next);
        end
        tick();
        sb_clear();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        expect_push(32'hFFFF_FFFC);
        @(negedge Clk);
        n_checks++;
        if (Mem_Addr !== 32'hFFFF_FFFC || Instr_Valid !== 1'b0 || PC_Next !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_ack: Mem_Addr=%h Valid=%b PC_Next=%h, expected FFFFFFFC/0/00000000", Mem_Addr, Instr_Valid, PC_Next);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Mem_Addr !== 32'd0 || Instr_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_after: Mem_Addr=%h Valid=%b, expected 00000000/1", Mem_Addr, Instr_Valid);
        end
        tick();
    endtask

    task automatic test_misalign();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h102);
        @(negedge Clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++;
        if (PC_Next !== 32'h8) begin
            n_fail++;
            $display("FAIL trap_next: PC_Next=%h expected 00000008", PC_Next);
        end
        tick();
        sb_clear();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if (Fetch_Err !== 1'b1 || Mem_Req !== 1'b0 || Instr_Valid !== 1'b0 || PC_Next !== 32'h8) begin
                n_fail++;
                $display("FAIL trap_hold[%0d]: Fetch_Err=%b Mem_Req=%b Valid=%b PC_Next=%h, expected 1/0/0/8", i, Fetch_Err, Mem_Req, Instr_Valid, PC_Next);
            end
            tick();
        end
        do_reset();
        @(negedge Clk);
        n_checks++;
        if (Fetch_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_clear: Fetch_Err=%b expected 0", Fetch_Err);
        end
        tick();
`else
        n_checks++;
        if (PC_Next !== 32'h100 || Fetch_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL align_next: PC_Next=%h Fetch_Err=%b, expected 100/0", PC_Next, Fetch_Err);
        end
        tick();
        sb_clear();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        expect_push(32'h100);
        @(negedge Clk);
        n_checks++;
        if (Mem_Addr !== 32'h100 || Mem_Req !== 1'b1 || Fetch_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL align_fetch: Mem_Addr=%h Mem_Req=%b Fetch_Err=%b, expected 100/1/0", Mem_Addr, Mem_Req, Fetch_Err);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge Clk);
        n_checks++;
        if (Instr_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL align_valid: Valid=%b expected 1", Instr_Valid);
        end
        tick();
        n_checks++;
        if (sb_pc.size() != 0) begin
            n_fail++;
            $display("FAIL align_end: %0d entries left, expected 0", sb_pc.size());
        end
`endif
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch controller on the consumer side of the program-counter register. Each cycle it reads the current PC and drives the next PC back into the register, which loads its input unconditionally on every clock. It issues instruction-memory reads with a req/ack handshake and buffers returned words in a small FIFO. It presents them to decode with a valid/ready handshake and handles branch/jump redirects, including a redirect that arrives while a read is still outstanding.

## Interface
- BUF_DEPTH, 2: instruction buffer entries; legal values 2 or 4.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- PC_Out  in  32  current PC from the PC register.
- PC_Next  out  32  next PC, wired to the PC register input; combinational from state and inputs.
- Mem_Req  out  1  instruction read request.
- Mem_Addr  out  32  read address; equals PC_Out.
- Mem_Ack  in  1  read complete; Mem_Data valid in the same cycle.
- Mem_Data  in  32  instruction word.
- Redirect  in  1  branch/jump taken; one-cycle pulse.
- Redirect_Addr  in  32  target address.
- Instr  out  32  head-of-buffer instruction.
- Instr_PC  out  32  address of Instr.
- Instr_Valid  out  1  buffer non-empty.
- Instr_Ready  in  1  decode accepts the head entry.
- Fetch_Err  out  1  misaligned redirect trap; tied to 0 unless FETCH_MISALIGN_TRAP_EN is defined.

## Operation
- States:
  - IDLE: one cycle after Reset.
  - FETCH: normal fetching.
  - DRAIN: a redirect is pending behind an outstanding read.
  - ERR: trap.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DRAIN on Redirect while Mem_Req=1 and Mem_Ack=0.
  - DRAIN→FETCH on Mem_Ack.
  - Any state→ERR on a trap (macro builds only).
- Mem_Req = (state==FETCH or DRAIN) and (count<BUF_DEPTH, or a read is already outstanding).
- Once Mem_Req is asserted it stays high, with Mem_Addr stable, until Mem_Ack. At most one read is outstanding.
- PC_Next priority:
  1. Reset → 0.
  2. Redirect with no outstanding read → Redirect_Addr.
  3. Mem_Ack in DRAIN → the stored pending target.
  4. Mem_Ack in FETCH → PC_Out+4 (32-bit wrap, so 0xFFFFFFFC→0).
  5. Otherwise → PC_Out (hold).
- Push: on Mem_Ack in FETCH, write {Mem_Data, PC_Out} to the buffer. In DRAIN the acked data is discarded.
- Pop: when Instr_Valid and Instr_Ready.
- Instr and Instr_PC show the head entry and hold their last value while empty.
- Redirect flushes the buffer in the same cycle: count becomes 0 and Instr_Valid=0 next cycle. A redirect wins over a simultaneous pop or push.
- Redirect in the same cycle as Mem_Ack: the acked data is discarded, PC_Next=Redirect_Addr, and the state stays FETCH.
- Second redirect while in DRAIN: it overwrites the pending target, so the last one wins.
- Count is never pushed past BUF_DEPTH or popped below 0. A push and pop in the same cycle leave count unchanged.

## Timing
- Reset values: PC_Next=0, Mem_Req=0, Instr_Valid=0, Instr=0, Instr_PC=0, Fetch_Err=0, count=0, pending target=0, state IDLE.
- Reset mid-transaction abandons the outstanding read. A Mem_Ack that arrives afterwards in IDLE is ignored.
- First request: Mem_Req rises in the second cycle after Reset deasserts, with Mem_Addr=0.
- Ack in cycle N:
  - Instr_Valid=1 in N+1.
  - PC_Out=old+4 in N+1.
  - The next Mem_Req can be high in N+1.
- Peak throughput is one instruction per cycle when Mem_Ack is held high and Instr_Ready=1.
- Redirect in cycle N with no outstanding read: Mem_Addr=Redirect_Addr in N+1.
- Redirect during DRAIN: Mem_Addr=target in the cycle after the draining Mem_Ack.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A Redirect with Redirect_Addr[1:0]≠0 enters ERR instead of redirecting.
  - In ERR: Fetch_Err=1 (sticky), Mem_Req=0, PC_Next=PC_Out, buffer flushed, Instr_Valid=0.
  - Only Reset exits ERR.
- FETCH_MISALIGN_TRAP_EN undefined: Redirect_Addr[1:0] is forced to 00 and Fetch_Err=0.

## Test plan
- Reset then Mem_Ack=1 and Instr_Ready=1 every cycle:
  - Mem_Addr sequence 0,4,8,C on consecutive cycles.
  - Instr_PC follows one cycle later.
- Instr_Ready=0 with Mem_Ack=1, BUF_DEPTH=2:
  - Two pushes, then Mem_Req=0 and PC_Out holds at 8.
  - Raising Instr_Ready drains 0 then 4 and fetching resumes at 8.
- Redirect to 0x100 while Mem_Ack=0 at Mem_Addr 0x10:
  - Mem_Addr stays 0x10 until the ack and that data is discarded.
  - Next Mem_Addr=0x100; the buffer is flushed on the redirect cycle.
- Redirect to 0x200 coincident with Mem_Ack and a pop:
  - No push, Instr_Valid=0 next cycle, Mem_Addr=0x200.
- PC_Out=0xFFFFFFFC acked → PC_Next=0x00000000.
- Redirect_Addr=0x102:
  - With the macro: Fetch_Err=1, Mem_Req=0, holding until Reset.
  - Without the macro: fetch proceeds from 0x100.
